aes_cipher_result_queue: RTL and testbench

//  Buffers ciphertext blocks from the pipelined AES core (valid_out/cipher_text) in a small FIFO.

---
 rtl/aes_cipher_result_queue_if.sv | 41 ++++
 rtl/aes_cipher_result_queue.sv | 167 ++++++++++++++++
 tb/tb_aes_cipher_result_queue.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_cipher_result_queue_if.sv
// ----------------------------------------------------------------------------
// aes_cipher_result_queue_if
// Purpose : Bundles the signals between the AES core, the DCP config-load
//           path and the ciphertext result queue.
// Signals :
//   ct_valid     1-cycle strobe from the AES core, ct_data holds a block
//   ct_data      128-bit ciphertext block
//   config_hsk   config request valid this cycle
//   config_addr  16-bit request address
//   config_load  1 = load (read), 0 = store
//   out_valid    registered read-response valid
//   out_data     registered 64-bit read-response data
//   fifo_empty   queue holds no blocks
//   fifo_full    queue holds DEPTH blocks
//   overflow     sticky flag, a block was dropped while the queue was full
// Modports:
//   master : drives ct_* and config_*, observes responses and status
//   slave  : the queue itself
// ----------------------------------------------------------------------------
interface aes_cipher_result_queue_if;
    logic         ct_valid;
    logic [127:0] ct_data;
    logic         config_hsk;
    logic [15:0]  config_addr;
    logic         config_load;
    logic         out_valid;
    logic [63:0]  out_data;
    logic         fifo_empty;
    logic         fifo_full;
    logic         overflow;

    modport master (
        output ct_valid, ct_data, config_hsk, config_addr, config_load,
        input  out_valid, out_data, fifo_empty, fifo_full, overflow
    );

    modport slave (
        input  ct_valid, ct_data, config_hsk, config_addr, config_load,
        output out_valid, out_data, fifo_empty, fifo_full, overflow
    );
endinterface

// File: rtl/aes_cipher_result_queue.sv
// ----------------------------------------------------------------------------
// aes_cipher_result_queue
// Purpose : Small FIFO of ciphertext blocks from the pipelined AES core,
//           read out by the DCP config-load path as two 64-bit halves.
//           Loading the low half pops the head entry. A status word reports
//           occupancy, full/empty and a sticky overflow flag so back-to-back
//           encryptions are not silently lost.
// Ports   :
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    aes_cipher_result_queue_if.slave (ct_*, config_*, out_*, flags)
// Address map (loads):
//   RD_HIGH_ADDR  head[127:64], no state change
//   RD_LOW_ADDR   head[63:0], pops the head when not empty
//   STATUS_ADDR   {16'h0, drop_cnt, 16'h0, count[7:0], 5'h0, ovf, full, empty}
//   other         64'h0
// Stores to STATUS_ADDR clear the overflow flag (and the drop counter).
// Build option:
//   AES_RESULT_DROP_CNT_EN  when defined, adds a saturating 16-bit count of
//                           dropped blocks, reported in status[47:32];
//                           otherwise those bits read as zero.
// ----------------------------------------------------------------------------
module aes_cipher_result_queue #(
    parameter int          DATA_WIDTH   = 128,
    parameter int          DEPTH        = 4,
    parameter logic [15:0] RD_HIGH_ADDR = 16'h0050,
    parameter logic [15:0] RD_LOW_ADDR  = 16'h0060,
    parameter logic [15:0] STATUS_ADDR  = 16'h0070
) (
    input  logic                        clk,
    input  logic                        reset,
    aes_cipher_result_queue_if.slave    bus
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HALF_W = DATA_WIDTH / 2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;

    logic                  empty_flag;
    logic                  full_flag;
    logic                  ovf_flag;

    logic                  is_load;
    logic                  is_store;
    logic                  is_empty;
    logic                  is_full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  clr;

    logic [DATA_WIDTH-1:0] head;
    logic [15:0]           drop_cnt;
    logic [63:0]           status_word;
    logic [63:0]           rd_data;

    logic                  vld_p1;
    logic [63:0]           rdata_p1;

`ifdef AES_RESULT_DROP_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    always_comb begin
        is_load  = bus.config_hsk & bus.config_load;
        is_store = bus.config_hsk & ~bus.config_load;
        is_empty = (count == '0);
        is_full  = (count == CNT_W'(DEPTH));
        pop      = is_load && (bus.config_addr == RD_LOW_ADDR) && !is_empty;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        push     = bus.ct_valid && (!is_full || pop);
        drop     = bus.ct_valid && is_full && !pop;
        clr      = is_store && (bus.config_addr == STATUS_ADDR);
        count_nxt = count + CNT_W'(push) - CNT_W'(pop);

        head     = mem[rd_ptr];

        // Status is built from the registered state, i.e. before this cycle's push/pop.
        status_word = {16'h0, drop_cnt, 16'h0, 8'(count), 5'h0,
                       ovf_flag, full_flag, empty_flag};

        rd_data = 64'h0;
        if (bus.config_addr == RD_HIGH_ADDR) begin
            rd_data = is_empty ? 64'h0 : head[DATA_WIDTH-1:HALF_W];
        end else if (bus.config_addr == RD_LOW_ADDR) begin
            rd_data = is_empty ? 64'h0 : head[HALF_W-1:0];
        end else if (bus.config_addr == STATUS_ADDR) begin
            rd_data = status_word;
        end
    end

    // Storage array: data only, no reset; pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.ct_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty_flag <= 1'b1;
            full_flag  <= 1'b0;
            ovf_flag   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count      <= count_nxt;
            empty_flag <= (count_nxt == '0);
            full_flag  <= (count_nxt == CNT_W'(DEPTH));
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                ovf_flag <= 1'b1;
            end else if (clr) begin
                ovf_flag <= 1'b0;
            end
        end
    end

`ifdef AES_RESULT_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= 16'h0;
        end else if (drop) begin
            drop_cnt <= sat_inc16(drop_cnt);
        end else if (clr) begin
            drop_cnt <= 16'h0;
        end
    end
`else
    assign drop_cnt = 16'h0;
`endif

    // ---- stage p1: registered read response ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= 64'h0;
        end else begin
            vld_p1 <= is_load;
            if (is_load) begin
                rdata_p1 <= rd_data;
            end
        end
    end

    assign bus.out_valid  = vld_p1;
    assign bus.out_data   = rdata_p1;
    assign bus.fifo_empty = empty_flag;
    assign bus.fifo_full  = full_flag;
    assign bus.overflow   = ovf_flag;

endmodule

// File: tb/tb_aes_cipher_result_queue.sv
// ----------------------------------------------------------------------------
// tb_aes_cipher_result_queue
// Directed bench for aes_cipher_result_queue (DEPTH = 4). Each load pushes
// its expected response and the cycle it must appear in; a separate monitor
// compares every out_valid beat against the queue.
// ----------------------------------------------------------------------------
module tb_aes_cipher_result_queue;

    localparam logic [15:0] A_HI   = 16'h0050;
    localparam logic [15:0] A_LO   = 16'h0060;
    localparam logic [15:0] A_ST   = 16'h0070;
    localparam logic [15:0] A_OTH  = 16'h0020;
    localparam logic [127:0] C0    = 128'h00112233_44556677_8899AABB_CCDDEEFF;
`ifdef AES_RESULT_DROP_CNT_EN
    localparam logic [63:0] DROP1  = 64'h0000_0001_0000_0000;
`else
    localparam logic [63:0] DROP1  = 64'h0;
`endif

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    aes_cipher_result_queue_if bus ();

    aes_cipher_result_queue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Block i: upper half 64'h1111_0000_0000_00ii, lower half 64'h2222_0000_0000_00ii
    function automatic logic [63:0] hi(input int i);
        return 64'h1111_0000_0000_0000 | 64'(i);
    endfunction
    function automatic logic [63:0] lo(input int i);
        return 64'h2222_0000_0000_0000 | 64'(i);
    endfunction
    function automatic logic [127:0] blk(input int i);
        return {hi(i), lo(i)};
    endfunction

    task automatic idle_inputs();
        bus.ct_valid    = 1'b0;
        bus.ct_data     = 128'h0;
        bus.config_hsk  = 1'b0;
        bus.config_addr = 16'h0;
        bus.config_load = 1'b0;
    endtask

    // One cycle of stimulus; loads record their expected response.
    task automatic step(input logic cv, input logic [127:0] cd, input logic hsk,
                        input logic [15:0] addr, input logic ld, input logic [63:0] expv);
        exp_t e;
        bus.ct_valid    = cv;
        bus.ct_data     = cd;
        bus.config_hsk  = hsk;
        bus.config_addr = addr;
        bus.config_load = ld;
        if (hsk && ld) begin
            e.data = expv;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic push_blk(input logic [127:0] d);
        step(1'b1, d, 1'b0, 16'h0, 1'b0, 64'h0);
    endtask

    task automatic load(input logic [15:0] addr, input logic [63:0] expv);
        step(1'b0, 128'h0, 1'b1, addr, 1'b1, expv);
    endtask

    task automatic store(input logic [15:0] addr);
        step(1'b0, 128'h0, 1'b1, addr, 1'b0, 64'h0);
    endtask

    task automatic chk1(input string name, input logic act, input logic expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s: got %0b expected %0b", name, act, expv);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_resp: out_data=%h at cycle %0d with no load outstanding",
                         bus.out_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_data !== e.data || cyc != e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL resp_data: got %h at cycle %0d expected %h at cycle %0d",
                             bus.out_data, cyc, e.data, e.cyc);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            checks = checks + 1;
            errors = errors + 1;
            e = exp_q.pop_front();
            $display("FAIL missing_resp: out_valid=%b at cycle %0d expected data %h",
                     bus.out_valid, cyc, e.data);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk1("rst_empty", bus.fifo_empty, 1'b1);
        chk1("rst_full", bus.fifo_full, 1'b0);
        chk1("rst_overflow", bus.overflow, 1'b0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        load(A_ST, 64'h1);

        // Single block round trip
        push_blk(C0);
        load(A_HI, 64'h0011223344556677);
        load(A_ST, 64'h100);
        load(A_LO, 64'h8899AABBCCDDEEFF);
        chk1("c0_empty_after_pop", bus.fifo_empty, 1'b1);
        load(A_ST, 64'h1);

        // Fill past DEPTH: B4 is dropped
        for (int i = 0; i < 5; i++) push_blk(blk(i));
        chk1("fill_full", bus.fifo_full, 1'b1);
        chk1("fill_overflow", bus.overflow, 1'b1);
        chk1("fill_empty", bus.fifo_empty, 1'b0);
        load(A_ST, 64'h406 | DROP1);

        // Push B5 while full, with a same-cycle pop
        load(A_HI, hi(0));
        step(1'b1, blk(5), 1'b1, A_LO, 1'b1, lo(0));
        chk1("pushpop_full_full", bus.fifo_full, 1'b1);
        chk1("pushpop_full_ovf", bus.overflow, 1'b1);
        load(A_ST, 64'h406 | DROP1);

        // Drain: B1, B2, B3, B5 in order
        load(A_HI, hi(1)); load(A_LO, lo(1));
        load(A_HI, hi(2)); load(A_LO, lo(2));
        load(A_HI, hi(3)); load(A_LO, lo(3));
        load(A_HI, hi(5)); load(A_LO, lo(5));
        chk1("drain_empty", bus.fifo_empty, 1'b1);
        chk1("drain_full", bus.fifo_full, 1'b0);

        // Loads while empty, and to an unmapped address
        load(A_LO, 64'h0);
        load(A_ST, 64'h5 | DROP1);
        load(A_OTH, 64'h0);
        load(A_HI, 64'h0);

        // Clearing the sticky overflow
        store(A_ST);
        chk1("clr_overflow", bus.overflow, 1'b0);
        load(A_ST, 64'h1);

        // Drop coinciding with a clear: set wins
        for (int i = 10; i < 14; i++) push_blk(blk(i));
        step(1'b1, blk(14), 1'b1, A_ST, 1'b0, 64'h0);
        chk1("drop_vs_clear_ovf", bus.overflow, 1'b1);
        store(A_OTH);
        chk1("store_other_ovf", bus.overflow, 1'b1);
        store(A_ST);
        chk1("clr2_overflow", bus.overflow, 1'b0);
        load(A_ST, 64'h402);

        // Reset during a load: no response, contents discarded
        reset           = 1'b1;
        bus.config_hsk  = 1'b1;
        bus.config_load = 1'b1;
        bus.config_addr = A_LO;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        chk1("rstload_no_valid", bus.out_valid, 1'b0);
        chk1("rstload_empty", bus.fifo_empty, 1'b1);
        chk1("rstload_full", bus.fifo_full, 1'b0);
        load(A_ST, 64'h1);

        // After reset: C0 plus a push/pop in a partially filled queue
        push_blk(C0);
        push_blk(blk(20));
        load(A_HI, 64'h0011223344556677);
        step(1'b1, blk(21), 1'b1, A_LO, 1'b1, 64'h8899AABBCCDDEEFF);
        load(A_ST, 64'h200);
        load(A_HI, hi(20)); load(A_LO, lo(20));
        load(A_HI, hi(21)); load(A_LO, lo(21));
        chk1("mid_empty", bus.fifo_empty, 1'b1);

        // Push and pop on an empty queue: pop reads empty, push is kept
        step(1'b1, blk(30), 1'b1, A_LO, 1'b1, 64'h0);
        load(A_ST, 64'h100);
        load(A_LO, lo(30));
        chk1("final_empty", bus.fifo_empty, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL outstanding_resp: %0d responses still pending, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
